// File: rtl/md_sched_pkg.sv
// Shared encodings for the multiply/divide sequencer: MD opcodes, FSM states
// and the decode helpers that classify an MD opcode.
package md_sched_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_RSV6  = 3'd6,
        MD_RSV7  = 3'd7
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // Multi-cycle arithmetic (MULT/MULTU/DIV/DIVU) occupies the low half of the opcode space.
    function automatic logic md_is_arith(input logic [2:0] op);
        return ~op[2];
    endfunction

    function automatic logic md_is_div(input logic [2:0] op);
        return (op[2:1] == 2'b01);
    endfunction

    function automatic logic md_is_move(input logic [2:0] op);
        return (op == MD_MTHI) || (op == MD_MTLO);
    endfunction

endpackage

// File: rtl/md_sched_if.sv
// Handshake bundle between the EX/D stages and the MD sequencer.
interface md_sched_if;

    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        d_md_use;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, src_a, src_b, d_md_use,
        input  busy, stall, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, d_md_use,
        output busy, stall, hi, lo
    );

endinterface

// File: rtl/md_sched_arith.sv
// Combinational 64-bit product / quotient-remainder generator for the MD unit.
// op_sel[1] picks divide over multiply, op_sel[0] picks unsigned over signed.
module md_arith (
    input  logic [1:0]  op_sel,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_zero
);

    logic        is_signed;
    logic        neg_a;
    logic        neg_b;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] product;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] divisor;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] quot;
    logic [31:0] rem;

    // Signed divide works on magnitudes, then restores signs: the quotient
    // truncates toward zero and the remainder follows the dividend. This
    // naturally yields 0x80000000 / -1 = 0x80000000 rem 0 without a trap.
    always_comb begin
        is_signed = ~op_sel[0];
        neg_a     = is_signed & a[31];
        neg_b     = is_signed & b[31];
        ext_a     = {{32{neg_a}}, a};
        ext_b     = {{32{neg_b}}, b};
        product   = ext_a * ext_b;
        mag_a     = neg_a ? (~a + 32'd1) : a;
        mag_b     = neg_b ? (~b + 32'd1) : b;
        divisor   = (b == 32'd0) ? 32'd1 : mag_b;
        uq        = mag_a / divisor;
        ur        = mag_a % divisor;
        quot      = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
        rem       = neg_a ? (~ur + 32'd1) : ur;
        if (op_sel[1]) begin
            res_hi = rem;
            res_lo = quot;
        end else begin
            res_hi = product[63:32];
            res_lo = product[31:0];
        end
    end

    assign div_zero = (b == 32'd0);

endmodule

// File: rtl/md_sched.sv
// Multiply/divide sequencer beside the EX ALU: owns HI/LO, models MD latency
// with a busy counter and raises the D-stage stall while an op is in flight.
module md_sched
    import md_sched_pkg::*;
#(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic        clk,
    input  logic        reset,
    md_sched_if.slave   md
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT) + 1;

    md_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic        pend_ok_q, pend_ok_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] arith_hi;
    logic [31:0] arith_lo;
    logic        div_zero;
    logic        busy;

    md_arith u_arith (
        .op_sel   (md.op[1:0]),
        .a        (md.src_a),
        .b        (md.src_b),
        .res_hi   (arith_hi),
        .res_lo   (arith_lo),
        .div_zero (div_zero)
    );

    // The whole result is captured at issue; RUN only burns the latency and
    // commits on the last cycle. Any start seen outside IDLE is dropped.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_ok_d = pend_ok_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (md.start) begin
                    if (md_is_arith(md.op)) begin
                        pend_hi_d = arith_hi;
                        pend_lo_d = arith_lo;
                        pend_ok_d = ~(md_is_div(md.op) & div_zero);
                        cnt_d     = md_is_div(md.op) ? CW'(DIV_LAT) : CW'(MUL_LAT);
                        state_d   = ST_RUN;
                    end else if (md.op == MD_MTHI) begin
                        hi_d = md.src_a;
                    end else if (md.op == MD_MTLO) begin
                        lo_d = md.src_a;
                    end
                end
            end
            ST_RUN: begin
                if (cnt_q == CW'(1)) begin
                    if (pend_ok_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Reset aborts any operation in flight, so nothing commits after release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_ok_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_ok_q <= pend_ok_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy     = (state_q == ST_RUN);
    assign md.busy  = busy;
    assign md.stall = md.d_md_use & (busy | (md.start & md_is_arith(md.op)));
    assign md.hi    = hi_q;
    assign md.lo    = lo_q;

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: a vector table plus hand-written corner
// sequences, with expected HI/LO queued at issue and popped when busy falls.
module tb_md_sched;
    import md_sched_pkg::*;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } result_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        md_use;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    int          checks = 0;
    int          errors = 0;
    result_t     sb[$];
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    vec_t        vecs[7];

    md_sched_if bus();

    md_sched #(.MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=still running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
        end
    endtask

    // Drives one start pulse for a cycle; optionally queues the expected result.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic md_use, input logic push,
                                 input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        result_t r;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.op       = op;
        bus.src_a    = a;
        bus.src_b    = b;
        bus.d_md_use = md_use;
        if (push) begin
            r.hi = exp_hi;
            r.lo = exp_lo;
            sb.push_back(r);
        end
        #1;
        if (md_use && op <= 3'd3) checkOutput("stall_on_start", {31'd0, bus.stall}, 32'd1);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Counts busy cycles (bounded), checks HI/LO hold and stall, then pops the scoreboard.
    task automatic waitCommit(input string name, input int exp_lat, input logic exp_stall);
        int      n = 0;
        bit      held = 1'b1;
        bit      stall_ok = 1'b1;
        bit      done = 1'b0;
        result_t exp;
        for (int k = 0; k < 64 && !done; k++) begin
            if (bus.busy === 1'b1) begin
                n++;
                if (bus.hi !== m_hi || bus.lo !== m_lo) held = 1'b0;
                if (bus.stall !== exp_stall) stall_ok = 1'b0;
                @(negedge clk);
            end else begin
                done = 1'b1;
            end
        end
        checkOutput({name, "_done"}, {31'd0, done}, 32'd1);
        checkOutput({name, "_lat"}, n, exp_lat);
        checkOutput({name, "_held"}, {31'd0, held}, 32'd1);
        checkOutput({name, "_stall"}, {31'd0, stall_ok}, 32'd1);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_sb: actual=empty queue required=entry", name);
        end else begin
            exp = sb.pop_front();
            checkOutput({name, "_hi"}, bus.hi, exp.hi);
            checkOutput({name, "_lo"}, bus.lo, exp.lo);
            m_hi = exp.hi;
            m_lo = exp.lo;
        end
    endtask

    function automatic result_t modelMd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        result_t r;
        longint  sp;
        logic [63:0] up;
        r = '0;
        case (op)
            MD_MULT: begin
                sp   = longint'(int'(a)) * longint'(int'(b));
                r.hi = sp[63:32];
                r.lo = sp[31:0];
            end
            MD_MULTU: begin
                up   = 64'(a) * 64'(b);
                r.hi = up[63:32];
                r.lo = up[31:0];
            end
            MD_DIVU: begin
                r.lo = a / b;
                r.hi = a % b;
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    initial begin
        bit          busy_seen;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        result_t     rexp;

        vecs[0] = '{MD_MULT,  32'hFFFFFFFF, 32'd2,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFFE, 5};
        vecs[1] = '{MD_MULTU, 32'hFFFFFFFF, 32'd2,        1'b0, 32'h00000001, 32'hFFFFFFFE, 5};
        vecs[2] = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3] = '{MD_DIVU,  32'd7,        32'd2,        1'b0, 32'h00000001, 32'h00000003, 10};
        vecs[4] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h80000000, 10};
        vecs[5] = '{MD_MULT,  32'h80000000, 32'd1,        1'b0, 32'hFFFFFFFF, 32'h80000000, 5};
        vecs[6] = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 1'b0, 32'h00000001, 32'hFFFFFFFD, 10};

        bus.start    = 1'b0;
        bus.op       = 3'd0;
        bus.src_a    = 32'd0;
        bus.src_b    = 32'd0;
        bus.d_md_use = 1'b0;
        reset        = 1'b1;
        m_hi         = 32'd0;
        m_lo         = 32'd0;
        #2;
        reset = 1'b0;
        #1;
        checkOutput("reset_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("reset_hi", bus.hi, 32'd0);
        checkOutput("reset_lo", bus.lo, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].md_use, 1'b1, vecs[i].exp_hi, vecs[i].exp_lo);
            waitCommit($sformatf("vec%0d", i), vecs[i].lat, vecs[i].md_use);
        end

        for (int i = 0; i < 6; i++) begin
            rop = (i % 3 == 0) ? MD_MULT : ((i % 3 == 1) ? MD_MULTU : MD_DIVU);
            ra  = $urandom;
            rb  = (rop == MD_DIVU) ? $urandom_range(1, 1000) : $urandom;
            rexp = modelMd(rop, ra, rb);
            applyStimulus(rop, ra, rb, 1'b0, 1'b1, rexp.hi, rexp.lo);
            waitCommit($sformatf("rand%0d", i), (rop == MD_DIVU) ? 10 : 5, 1'b0);
        end

        applyStimulus(MD_MTHI, 32'h11, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        checkOutput("mthi_hi", bus.hi, 32'h11);
        checkOutput("mthi_busy", {31'd0, bus.busy}, 32'd0);
        applyStimulus(MD_MTLO, 32'h22, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        checkOutput("mtlo_lo", bus.lo, 32'h22);
        checkOutput("mtlo_hi", bus.hi, 32'h11);
        m_hi = 32'h11;
        m_lo = 32'h22;
        applyStimulus(MD_DIV, 32'd5, 32'd0, 1'b0, 1'b1, 32'h11, 32'h22);
        waitCommit("div0", 10, 1'b0);

        applyStimulus(MD_DIV, 32'd100, 32'd7, 1'b1, 1'b1, 32'd2, 32'd14);
        waitCommit("stall_div", 10, 1'b1);
        checkOutput("stall_after", {31'd0, bus.stall}, 32'd0);
        bus.d_md_use = 1'b0;

        applyStimulus(MD_DIVU, 32'd7, 32'd2, 1'b0, 1'b1, 32'd1, 32'd3);
        applyStimulus(MD_MULT, 32'd3, 32'd3, 1'b0, 1'b0, 32'd0, 32'd0);
        applyStimulus(MD_MTHI, 32'hDEAD, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        waitCommit("run_start", 6, 1'b0);

        applyStimulus(MD_MULT, 32'd3, 32'd4, 1'b0, 1'b1, 32'd0, 32'd12);
        repeat (3) @(negedge clk);
        applyStimulus(MD_MULT, 32'd5, 32'd5, 1'b0, 1'b0, 32'd0, 32'd0);
        waitCommit("commit_start", 0, 1'b0);
        @(negedge clk);
        checkOutput("commit_start_idle", {31'd0, bus.busy}, 32'd0);
        checkOutput("commit_start_keep", bus.lo, 32'd12);

        applyStimulus(MD_MTHI, 32'h55, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        applyStimulus(MD_MULT, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("abort_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("abort_hi", bus.hi, 32'd0);
        checkOutput("abort_lo", bus.lo, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        busy_seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.busy !== 1'b0) busy_seen = 1'b1;
        end
        checkOutput("abort_no_busy", {31'd0, busy_seen}, 32'd0);
        checkOutput("abort_no_commit_hi", bus.hi, 32'd0);
        checkOutput("abort_no_commit_lo", bus.lo, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
